// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU MEM-stage port, DMA/loader port, data-memory port and
// statistics outputs of the data-memory arbiter, bundled in one interface.
// slave  = the arbiter's view; master = the surrounding pipeline/DMA/memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cpu_stall;

  logic              dma_valid;
  logic              dma_write;
  logic [ADDR_W-1:0] dma_address;
  logic [DATA_W-1:0] dma_write_data;
  logic              dma_ready;
  logic [DATA_W-1:0] dma_read_data;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic [15:0]       stat_cpu_stall_cycles;
  logic [15:0]       stat_dma_grants;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data,
    input  dma_valid, dma_write, dma_address, dma_write_data,
    input  mem_read_data,
    output cpu_read_data, cpu_stall,
    output dma_ready, dma_read_data,
    output mem_address, mem_read, mem_write, mem_write_data,
    output stat_cpu_stall_cycles, stat_dma_grants
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data,
    output dma_valid, dma_write, dma_address, dma_write_data,
    output mem_read_data,
    input  cpu_read_data, cpu_stall,
    input  dma_ready, dma_read_data,
    input  mem_address, mem_read, mem_write, mem_write_data,
    input  stat_cpu_stall_cycles, stat_dma_grants
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM-stage CPU
// port and a DMA/loader port. CPU wins by default; a DMA port blocked for
// MAX_WAIT consecutive cycles is handed a burst of up to BURST_LEN accesses.
// Grant is combinational from registered state and the current requests.
// Optional macro DMEM_ARB_STATS_EN builds saturating stall/grant counters;
// without it both statistics outputs are tied to zero.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// CPU_PRI   | CPU granted when requesting; DMA only in idle slots, wait_cnt
//           | counts consecutive blocked DMA cycles
// DMA_BURST | DMA granted while dma_valid, burst_cnt counts the accesses;
//           | ends after BURST_LEN accesses or as soon as dma_valid drops
module dmem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 2
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    CPU_PRI   = 1'b0,
    DMA_BURST = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;

  logic        cpu_req;
  logic        cpu_grant;
  logic        dma_grant;
  logic        cpu_stall;

  logic [ADDR_W-1:0] mux_address;
  logic [DATA_W-1:0] mux_write_data;
  logic              mux_read;
  logic              mux_write;

  assign cpu_req = bus.cpu_mem_read | bus.cpu_mem_write;

  // Grant decision and next-state / counter update; nothing is granted in reset
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    cpu_grant   = 1'b0;
    dma_grant   = 1'b0;
    if (!rst) begin
      case (state_q)
        CPU_PRI: begin
          if (cpu_req) begin
            cpu_grant = 1'b1;
            if (bus.dma_valid) begin
              if (wait_cnt_q == WAIT_LAST) begin
                state_d     = DMA_BURST;
                wait_cnt_d  = 8'd0;
                burst_cnt_d = 8'd0;
              end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
              end
            end else begin
              wait_cnt_d = 8'd0;
            end
          end else begin
            dma_grant  = bus.dma_valid;
            wait_cnt_d = 8'd0;
          end
        end
        DMA_BURST: begin
          if (bus.dma_valid) begin
            dma_grant = 1'b1;
            if (burst_cnt_q == BURST_LAST) begin
              state_d     = CPU_PRI;
              wait_cnt_d  = 8'd0;
              burst_cnt_d = 8'd0;
            end else begin
              burst_cnt_d = burst_cnt_q + 8'd1;
            end
          end else begin
            // DMA went away mid-burst: hand the slot straight back to the CPU
            cpu_grant   = cpu_req;
            state_d     = CPU_PRI;
            wait_cnt_d  = 8'd0;
            burst_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d     = CPU_PRI;
          wait_cnt_d  = 8'd0;
          burst_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CPU_PRI;
      wait_cnt_q  <= 8'd0;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Memory port mux: granted requester drives the memory, idle drives zeros
  always_comb begin
    mux_address    = '0;
    mux_write_data = '0;
    mux_read       = 1'b0;
    mux_write      = 1'b0;
    if (cpu_grant) begin
      mux_address    = bus.cpu_address;
      mux_write_data = bus.cpu_write_data;
      mux_read       = bus.cpu_mem_read;
      mux_write      = bus.cpu_mem_write;
    end else if (dma_grant) begin
      mux_address    = bus.dma_address;
      mux_write_data = bus.dma_write_data;
      mux_read       = ~bus.dma_write;
      mux_write      = bus.dma_write;
    end
  end

  assign cpu_stall          = cpu_req & ~cpu_grant & ~rst;

  assign bus.mem_address    = mux_address;
  assign bus.mem_write_data = mux_write_data;
  assign bus.mem_read       = mux_read;
  assign bus.mem_write      = mux_write;

  assign bus.cpu_stall      = cpu_stall;
  assign bus.dma_ready      = dma_grant;

  // Read data fans out to both ports; each port qualifies it with its grant
  assign bus.cpu_read_data  = bus.mem_read_data;
  assign bus.dma_read_data  = bus.mem_read_data;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] dma_grants_q, dma_grants_d;

  // Saturating event counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    dma_grants_d   = dma_grants_q;
    if (cpu_stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (dma_grant && (dma_grants_q != 16'hFFFF)) begin
      dma_grants_d = dma_grants_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 16'd0;
      dma_grants_q   <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      dma_grants_q   <= dma_grants_d;
    end
  end

  assign bus.stat_cpu_stall_cycles = stall_cycles_q;
  assign bus.stat_dma_grants       = dma_grants_q;
`else
  assign bus.stat_cpu_stall_cycles = 16'd0;
  assign bus.stat_dma_grants       = 16'd0;
`endif

endmodule
